// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle for reg_writeback_ctrl: ALU result input, load issue/response
// handshakes, register-file write port, scoreboard and error flag.
// Handshake rule: a load response transfers only in a cycle where
// ld_resp_valid && ld_resp_ready; a load issue is taken only when
// ld_issue && ld_issue_ready; alu_valid is always taken.
interface reg_writeback_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_issue_ready;
  logic              ld_resp_valid;
  logic [DATA_W-1:0] ld_resp_data;
  logic              ld_resp_ready;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic [NREG-1:0]   busy_mask;
  logic              proto_err;

  // Execute/memory side: produces results, consumes readiness and status.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
           ld_resp_valid, ld_resp_data,
    input  ld_issue_ready, ld_resp_ready, rg_wrt_en, rg_wrt_addr,
           rg_wrt_data, busy_mask, proto_err
  );

  // Controller side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
           ld_resp_valid, ld_resp_data,
    output ld_issue_ready, ld_resp_ready, rg_wrt_en, rg_wrt_addr,
           rg_wrt_data, busy_mask, proto_err
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port controller. Merges ALU results and in-order load
// responses into one registered write stream, tracks outstanding load
// destinations in a small FIFO and publishes a busy-register scoreboard.
// Optional build macro WB_STALL_CNT_EN adds ld_hold_cycles, a saturating
// count of cycles where a parked load response was blocked by the ALU.
module reg_writeback_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int LD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_writeback_ctrl_if.slave   bus
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]           ld_hold_cycles
`endif
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  // Load destination FIFO
  logic [ADDR_W-1:0] q_rd_q [LD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     count_after_pop;

  // Hold register for a load response that lost to the ALU
  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_rd_q, hold_rd_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  // Registered write port and status
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              proto_q, proto_d;

  // Handshake decode
  logic              full, empty;
  logic              push, issue_drop;
  logic              resp_hs, accept, orphan;
  logic [ADDR_W-1:0] head_rd;

  // Write source selection
  logic              sel_valid, sel_is_load;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              still_busy;
  logic [PW-1:0]     idx;

  assign full       = (count_q == CW'(LD_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = bus.ld_issue && !full;
  assign issue_drop = bus.ld_issue && full;
  assign resp_hs    = bus.ld_resp_valid && !hold_v_q;
  assign accept     = resp_hs && !empty;
  assign orphan     = resp_hs && empty;
  assign head_rd    = q_rd_q[rd_ptr_q];

  // Pick this cycle's write source (ALU > hold > fresh response) and park
  // a response in the hold register when the ALU takes the port.
  always_comb begin
    sel_valid   = 1'b0;
    sel_is_load = 1'b0;
    sel_rd      = '0;
    sel_data    = '0;
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
      if (accept) begin
        hold_v_d    = 1'b1;
        hold_rd_d   = head_rd;
        hold_data_d = bus.ld_resp_data;
      end
    end else if (hold_v_q) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      sel_rd      = hold_rd_q;
      sel_data    = hold_data_q;
      hold_v_d    = 1'b0;
    end else if (accept) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      sel_rd      = head_rd;
      sel_data    = bus.ld_resp_data;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at LD_DEPTH.
  always_comb begin
    rd_ptr_d        = rd_ptr_q + PW'(accept);
    wr_ptr_d        = wr_ptr_q + PW'(push);
    count_after_pop = count_q - CW'(accept);
    count_d         = count_after_pop + CW'(push);
  end

  // Does any load still pending (queue after pop, or hold) target sel_rd?
  always_comb begin
    still_busy = 1'b0;
    idx        = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      idx = rd_ptr_d + PW'(i);
      if ((CW'(i) < count_after_pop) && (q_rd_q[idx] == sel_rd))
        still_busy = 1'b1;
    end
    if (hold_v_d && (hold_rd_d == sel_rd))
      still_busy = 1'b1;
  end

  // Scoreboard, write port and sticky error next-state; set beats clear.
  always_comb begin
    busy_d = busy_q;
    if (sel_valid && sel_is_load && (sel_rd != '0) && !still_busy)
      busy_d[sel_rd] = 1'b0;
    if (push && (bus.ld_rd != '0))
      busy_d[bus.ld_rd] = 1'b1;
    busy_d[0] = 1'b0;

    wr_en_d   = sel_valid && (sel_rd != '0);
    wr_addr_d = wr_en_d ? sel_rd : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;

    proto_d = proto_q || issue_drop || orphan;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_v_q    <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
      proto_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_v_q    <= hold_v_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      proto_q     <= proto_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && push)
      q_rd_q[wr_ptr_q] <= bus.ld_rd;
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;

  // Saturating count of cycles with a parked response blocked by the ALU.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (hold_v_q && bus.alu_valid && (hold_cnt_q != 16'hFFFF))
      hold_cnt_d = hold_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end

  assign ld_hold_cycles = hold_cnt_q;
`endif

  assign bus.ld_issue_ready = !full;
  assign bus.ld_resp_ready  = !hold_v_q;
  assign bus.rg_wrt_en      = wr_en_q;
  assign bus.rg_wrt_addr    = wr_addr_q;
  assign bus.rg_wrt_data    = wr_data_q;
  assign bus.busy_mask      = busy_q;
  assign bus.proto_err      = proto_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_reg_writeback_ctrl;
  localparam int LD_DEPTH = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.DATA_W(32), .ADDR_W(5), .NREG(32)) bus ();

`ifdef WB_STALL_CNT_EN
  logic [15:0] ld_hold_cycles;
`endif

  reg_writeback_ctrl #(.DATA_W(32), .ADDR_W(5), .NREG(32), .LD_DEPTH(LD_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WB_STALL_CNT_EN
    ,
    .ld_hold_cycles (ld_hold_cycles)
`endif
  );

  // Scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  // Reference model state
  logic [4:0]  pend_q[$];
  bit          m_hold_v;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  bit          m_proto;
  bit          m_exp_en;
  bit          m_rst_chk;
  bit          m_started;
  int          m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Busy set = every non-zero rd still owed by an outstanding load.
  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (pend_q[i]) m[pend_q[i]] = 1'b1;
    if (m_hold_v) m[m_hold_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs();
    logic [36:0] w;
    chk("wr_en", 64'(bus.rg_wrt_en), 64'(m_exp_en));
    if (bus.rg_wrt_en === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
      else begin
        w = exp_q.pop_front();
        chk("wr_addr_data", 64'({bus.rg_wrt_addr, bus.rg_wrt_data}), 64'(w));
      end
    end else if (m_exp_en && exp_q.size() != 0) begin
      w = exp_q.pop_front();
    end
    chk("busy_mask", 64'(bus.busy_mask), 64'(model_busy()));
    chk("issue_ready", 64'(bus.ld_issue_ready), 64'(pend_q.size() != LD_DEPTH));
    chk("resp_ready", 64'(bus.ld_resp_ready), 64'(!m_hold_v));
    chk("proto_err", 64'(bus.proto_err), 64'(m_proto));
    if (m_rst_chk) begin
      chk("rst_addr", 64'(bus.rg_wrt_addr), 64'(0));
      chk("rst_data", 64'(bus.rg_wrt_data), 64'(0));
      m_rst_chk = 1'b0;
    end
`ifdef WB_STALL_CNT_EN
    chk("hold_cycles", 64'(ld_hold_cycles), 64'(m_stall));
`endif
  endtask

  task automatic model_update(input bit rst, input bit av, input logic [4:0] ard,
                              input logic [31:0] ad, input bit iss, input logic [4:0] ird,
                              input bit rv, input logic [31:0] rdat);
    bit          acc, orph, full, wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      m_hold_v  = 1'b0;
      m_proto   = 1'b0;
      m_exp_en  = 1'b0;
      m_stall   = 0;
      m_rst_chk = 1'b1;
      return;
    end
    full = (pend_q.size() == LD_DEPTH);
    acc  = rv && !m_hold_v && pend_q.size() > 0;
    orph = rv && !m_hold_v && pend_q.size() == 0;
    if (av && m_hold_v && m_stall < 65535) m_stall++;
    wv = 1'b0; wrd = '0; wd = '0;
    if (av) begin
      wv = 1'b1; wrd = ard; wd = ad;
      if (acc) begin
        m_hold_v = 1'b1; m_hold_rd = pend_q[0]; m_hold_data = rdat;
      end
    end else if (m_hold_v) begin
      wv = 1'b1; wrd = m_hold_rd; wd = m_hold_data; m_hold_v = 1'b0;
    end else if (acc) begin
      wv = 1'b1; wrd = pend_q[0]; wd = rdat;
    end
    if (acc) void'(pend_q.pop_front());
    if (iss) begin
      if (full) m_proto = 1'b1;
      else pend_q.push_back(ird);
    end
    if (orph) m_proto = 1'b1;
    m_exp_en = wv && (wrd != 0);
    if (m_exp_en) exp_q.push_back({wrd, wd});
  endtask

  // One clock of stimulus: check last cycle's outputs, then drive and model.
  task automatic step(input bit rst, input bit av, input logic [4:0] ard,
                      input logic [31:0] ad, input bit iss, input logic [4:0] ird,
                      input bit rv, input logic [31:0] rdat);
    @(negedge clk);
    if (m_started) check_outputs();
    m_started = 1'b1;
    reset             = rst;
    bus.alu_valid     = av;
    bus.alu_rd        = ard;
    bus.alu_data      = ad;
    bus.ld_issue      = iss;
    bus.ld_rd         = ird;
    bus.ld_resp_valid = rv;
    bus.ld_resp_data  = rdat;
    model_update(rst, av, ard, ad, iss, ird, rv, rdat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_issue = 0; bus.ld_rd = 0;
    bus.ld_resp_valid = 0; bus.ld_resp_data = 0;
    m_started = 0; m_hold_v = 0; m_proto = 0; m_exp_en = 0; m_stall = 0; m_rst_chk = 0;

    // Reset, then a single ALU write to x5
    do_reset();
    do_reset();
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2);

    // Single load to x7, response three cycles later
    step(0, 0, 0, 0, 1, 7, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    idle(2);

    // Response collides with ALU writes to x3
    step(0, 0, 0, 0, 1, 10, 0, 0);
    idle(1);
    step(0, 1, 3, 32'h1, 0, 0, 1, 32'h0000AAAA);
    step(0, 1, 3, 32'h1, 0, 0, 0, 0);
    step(0, 1, 3, 32'h1, 0, 0, 0, 0);
    idle(3);

    // Fill the queue, overflow once, then drain in order
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, 5'(i), 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 0, 1, 32'h100 + 32'(i));
    idle(2);
    do_reset();

    // Two loads to x9: busy survives the first write
    step(0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h9A);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h9B);
    idle(2);

    // Reset with loads in flight, then an orphan response
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 32'h55);
    idle(2);
    do_reset();

    // Random traffic over a small register subset to force collisions
    for (int n = 0; n < 3000; n++) begin
      bit rst_r, av_r, iss_r, rv_r;
      rst_r = ($urandom_range(0, 299) == 0);
      av_r  = ($urandom_range(0, 2) == 0);
      iss_r = ($urandom_range(0, 1) == 1);
      if (pend_q.size() > 0) rv_r = ($urandom_range(0, 1) == 1);
      else                   rv_r = ($urandom_range(0, 39) == 0);
      step(rst_r, av_r, 5'($urandom_range(0, 7)), $urandom, iss_r,
           5'($urandom_range(0, 7)), rv_r, $urandom);
    end
    idle(4);
    @(negedge clk);
    check_outputs();
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
